// File: rtl/rwc_multi_ctrl_if.sv
// Challenge, BRAM and response signals for the RWC PUF controller.
// slave = controller side, master = sequencer/BRAM/consumer side.
interface rwc_multi_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              cha_valid;
    logic              cha_ready;
    logic [DATA_W-1:0] cha_data;
    logic [ADDR_W-1:0] cha_addr;
    logic              bram_wea;
    logic [ADDR_W-1:0] bram_addra;
    logic [DATA_W-1:0] bram_dina;
    logic [ADDR_W-1:0] bram_addrb;
    logic [DATA_W-1:0] bram_doutb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] rsp_mask;

    modport slave (
        input  cha_valid, cha_data, cha_addr, bram_doutb, rsp_ready,
        output cha_ready, bram_wea, bram_addra, bram_dina, bram_addrb,
               rsp_valid, rsp_data, rsp_mask
    );

    modport master (
        output cha_valid, cha_data, cha_addr, bram_doutb, rsp_ready,
        input  cha_ready, bram_wea, bram_addra, bram_dina, bram_addrb,
               rsp_valid, rsp_data, rsp_mask
    );
endinterface

// File: rtl/rwc_multi_ctrl.sv
// Read-write-collision PUF controller: REPEAT same-address write/read collisions
// per challenge, per-bit one-counting, majority response plus stability mask.
module rwc_multi_ctrl #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 10,
    parameter int                REPEAT    = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    rwc_multi_ctrl_if.slave     bus
);
    localparam int CNT_W = $clog2(REPEAT + 1);

    typedef enum logic [2:0] {IDLE, PRE, COL, CAP, FIN, OUT} state_t;

    state_t                        r_state, w_next;
    logic [ADDR_W-1:0]             r_addr;
    logic [DATA_W-1:0]             r_data;
    logic [DATA_W-1:0][CNT_W-1:0]  r_ones;
    logic [CNT_W-1:0]              r_rep;
    logic                          r_rsp_valid;
    logic [DATA_W-1:0]             r_rsp_data, r_rsp_mask;

    logic                          w_accept, w_rsp_fire, w_last;
    logic                          w_wea;
    logic [DATA_W-1:0]             w_dina, w_maj, w_stab;

    assign w_accept   = (r_state == IDLE) && bus.cha_valid;
    assign w_rsp_fire = r_rsp_valid && bus.rsp_ready;
    assign w_last     = (r_rep + CNT_W'(1)) == CNT_W'(REPEAT);

    // 2*ones > REPEAT evaluated one bit wider so the doubling cannot wrap
    always_comb begin
        w_maj  = '0;
        w_stab = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_maj[i]  = {r_ones[i], 1'b0} > (CNT_W + 1)'(REPEAT);
            w_stab[i] = (r_ones[i] == '0) || (r_ones[i] == CNT_W'(REPEAT));
        end
    end

    always_comb begin
        w_next = r_state;
        w_wea  = 1'b0;
        w_dina = CLEAR_VAL;
        case (r_state)
            IDLE: if (w_accept) w_next = PRE;
            PRE: begin
                w_wea  = 1'b1;
                w_next = COL;
            end
            COL: begin
                w_wea  = 1'b1;
                w_dina = r_data;
                w_next = CAP;
            end
            CAP:  w_next = w_last ? FIN : PRE;
            FIN: begin
                w_wea  = 1'b1;
                w_next = OUT;
            end
            OUT:  if (w_rsp_fire) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_ones      <= '0;
            r_rep       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_mask  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_addr <= bus.cha_addr;
                    r_data <= bus.cha_data;
                    r_ones <= '0;
                    r_rep  <= '0;
                end
                CAP: begin
                    for (int i = 0; i < DATA_W; i++)
                        r_ones[i] <= r_ones[i] + CNT_W'(bus.bram_doutb[i]);
                    r_rep <= r_rep + CNT_W'(1);
                end
                FIN: begin
                    r_rsp_data <= w_maj;
                    r_rsp_mask <= w_stab;
                end
                default: ;
            endcase
            // valid trails OUT entry by one cycle: accept-to-valid is 3*REPEAT+2
            r_rsp_valid <= (r_state == OUT) && !w_rsp_fire;
        end
    end

    assign bus.cha_ready  = (r_state == IDLE);
    assign bus.bram_wea   = w_wea;
    assign bus.bram_addra = r_addr;
    assign bus.bram_addrb = r_addr;
    assign bus.bram_dina  = w_dina;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_mask   = r_rsp_mask;
endmodule

// File: doc/rwc_multi_ctrl.md
Name: rwc_multi_ctrl

Overview:
Parametrised read-write-collision PUF generator controller, single clock.
- Accepts a challenge (address, data) over a valid/ready handshake.
- Provokes REPEAT same-address write/read collisions on an external true dual-port BRAM.
- Accumulates per-bit one-counts of the colliding read data across the repeats.
- Returns a majority-voted response plus a per-bit stability mask over a valid/ready handshake.
- Sits between the challenge sequencer and the response post-processing/ECC stage.

Parameters:
DATA_W, 32, BRAM data width and response width.
ADDR_W, 10, BRAM address width.
REPEAT, 8, collision repetitions per challenge; legal range 1..255.
CLEAR_VAL, 0, value written to the cell before each collision and after the final one.
(Derived localparam CNT_W = clog2(REPEAT+1); not overridable.)

Ports:
clk  in  1  single clock for all logic and both BRAM ports.
rst  in  1  synchronous, active-high reset.
cha_valid  in  1  challenge valid.
cha_ready  out  1  challenge ready; high only in IDLE.
cha_data  in  DATA_W  challenge write data.
cha_addr  in  ADDR_W  challenge BRAM address.
bram_wea  out  1  port-A write enable.
bram_addra  out  ADDR_W  port-A address.
bram_dina  out  DATA_W  port-A write data.
bram_addrb  out  ADDR_W  port-B (read-only) address.
bram_doutb  in  DATA_W  port-B read data; 1-cycle read latency.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response ready.
rsp_data  out  DATA_W  majority-voted response.
rsp_mask  out  DATA_W  1 = bit identical in all REPEAT samples.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state IDLE; latched addr/data, one-counters, repeat counter = 0; bram_wea=0; bram_dina=CLEAR_VAL; rsp_valid=0; rsp_data=0; rsp_mask=0; cha_ready=1 in the first cycle after reset deasserts.
- States: IDLE, PRE, COL, CAP, FIN, OUT.
  - IDLE: cha_ready=1. On cha_valid && cha_ready, latch cha_addr/cha_data, clear the one-counters and the repeat counter, then go to PRE.
  - PRE: wea=1, dina=CLEAR_VAL. Next state COL.
  - COL: wea=1, dina=latched data, port B reads the same address in the same cycle (the collision). Next state CAP.
  - CAP: wea=0. bram_doutb holds the collision read. For each bit i, ones[i] += doutb[i]. Repeat counter +1. Go to FIN if it reaches REPEAT, otherwise PRE.
  - FIN: wea=1, dina=CLEAR_VAL (post-clear). Register the result:
    - rsp_data[i] = (2*ones[i] > REPEAT), a strict majority; a tie gives 0.
    - rsp_mask[i] = (ones[i]==0) || (ones[i]==REPEAT).
    - Next state OUT.
  - OUT: wea=0, rsp_valid=1; rsp_data/rsp_mask stay stable. On rsp_ready go to IDLE and drop rsp_valid. rsp_data/rsp_mask keep their values until the next FIN.
- BRAM ports: bram_addra = bram_addrb = latched address in every state, including IDLE. bram_dina = CLEAR_VAL in every state except COL.
- Latency: with the accept edge at k, rsp_valid is first high after edge k+3*REPEAT+2 (26 cycles for REPEAT=8).
- Counters: each of the DATA_W one-counters is CNT_W bits and cannot overflow, since each is bounded by REPEAT. The repeat counter is also CNT_W bits.
- cha_valid outside IDLE is ignored, with no latching. There is one bubble minimum between an accepted rsp and the next cha accept.
- REPEAT=1: rsp_data = the single sample; rsp_mask = all ones.
- Reset mid-operation: at the next edge the state is IDLE, bram_wea=0, rsp_valid=0, and all counters are cleared. No post-clear write is issued. A challenge accepted afterwards is processed from scratch.
- rsp_ready high while not in OUT has no effect.

Test Plan:
1. Assert rst 3 cycles -> all outputs at reset values, cha_ready=1; rst mid-cycle has no effect until the edge.
2. REPEAT=8, addr 0x155, data 0xA5A5A5A5, BRAM model returns 0xA5A5A5A5 in every CAP -> rsp_data=0xA5A5A5A5, rsp_mask=0xFFFFFFFF, rsp_valid 26 cycles after accept. Per-repeat write trace: CLEAR_VAL, then 0xA5A5A5A5 at addr 0x155, then post-clear in FIN.
3. REPEAT=8, model returns 0xFFFF0000 for 5 repeats and 0x0000FFFF for 3 -> rsp_data=0xFFFF0000, rsp_mask=0x00000000.
4. REPEAT=8 tie: bit0=1 for 4 repeats, 0 for 4, other bits always 1 -> rsp_data=0xFFFFFFFE, rsp_mask=0xFFFFFFFE.
5. Backpressure: rsp_ready low for 10 cycles in OUT while cha_valid pulses -> rsp_valid/rsp_data held, cha_ready=0, no new latch. Release -> IDLE next edge, next challenge accepted one cycle later.
6. Reset asserted in COL of repeat 3 -> next edge: IDLE, wea=0, rsp_valid=0. A fresh challenge then completes with the correct all-stable result and 26-cycle latency.
